// File: rtl/mem_port_arb4_if.sv
// Bundle of requester-side and memory-side signals for the four-client memory port arbiter.
// The optional err flag is present only when ARB_TIMEOUT_EN is defined.
interface mem_port_arb4_if;
    logic [3:0]  req;
    logic [3:0]  wr;
    logic [15:0] addr0, addr1, addr2, addr3;
    logic [15:0] wdata0, wdata1, wdata2, wdata3;
    logic        mem_done;
    logic [15:0] mem_rdata;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [1:0]  sel;
    logic [3:0]  ack;
    logic [15:0] rdata;
    logic        busy;
`ifdef ARB_TIMEOUT_EN
    logic        err;
`endif
    // Arbiter FSM state: 0 idle, 1 issue, 2 wait.
    logic [1:0]  state_dbg;

    // Handshake: a requester raises req[i] with wr/addr/wdata and holds them stable
    // until ack[i] pulses; the memory sees one mem_en strobe and answers with a
    // mem_done pulse carrying mem_rdata in a later cycle.
    modport slave (
        input  req, wr, addr0, addr1, addr2, addr3,
        input  wdata0, wdata1, wdata2, wdata3,
        input  mem_done, mem_rdata,
        output mem_en, mem_wr, mem_addr, mem_wdata,
        output sel, ack, rdata, busy,
`ifdef ARB_TIMEOUT_EN
        output err,
`endif
        output state_dbg
    );

    modport master (
        output req, wr, addr0, addr1, addr2, addr3,
        output wdata0, wdata1, wdata2, wdata3,
        output mem_done, mem_rdata,
        input  mem_en, mem_wr, mem_addr, mem_wdata,
        input  sel, ack, rdata, busy,
`ifdef ARB_TIMEOUT_EN
        input  err,
`endif
        input  state_dbg
    );
endinterface

// File: rtl/mem_port_arb4.sv
// Round-robin arbiter for the shared 16-bit memory port: grant, one-cycle issue, wait, ack.
// Define ARB_TIMEOUT_EN to add a WAIT watchdog that forces completion with err=1.
module mux4_1_16 (
    input  logic [15:0] d0,
    input  logic [15:0] d1,
    input  logic [15:0] d2,
    input  logic [15:0] d3,
    input  logic [1:0]  s,
    output logic [15:0] y
);
    always_comb begin
        case (s)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end
endmodule

module mem_port_arb4 #(
    parameter int TIMEOUT = 15
) (
    input logic            clk,
    input logic            rst_n,
    mem_port_arb4_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] ptr;
    logic [1:0] sel_q;
    logic       g_wr;
    logic [1:0] gnt_idx;
    logic       gnt_found;
    logic [1:0] cand;
    logic       done_ok;
    logic       to_hit;

    // First set request bit searching ptr, ptr+1, ... wrapping mod 4.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = ptr;
        cand      = ptr;
        for (int i = 0; i < 4; i++) begin
            cand = ptr + 2'(i);
            if (!gnt_found && bus.req[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign done_ok = (state == S_WAIT) && bus.mem_done;

`ifdef ARB_TIMEOUT_EN
    logic [3:0] wcnt;
    logic       err_q;

    // mem_done wins over a watchdog expiry in the same cycle.
    assign to_hit = (state == S_WAIT) && !bus.mem_done && (wcnt == 4'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt <= 4'd0;
        end else if (state == S_ISSUE) begin
            wcnt <= 4'd0;
        end else if (state == S_WAIT && !bus.mem_done && !to_hit) begin
            wcnt <= wcnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= to_hit;
        end
    end

    assign bus.err = err_q;
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (gnt_found) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (done_ok || to_hit) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= 2'd0;
            sel_q     <= 2'd0;
            g_wr      <= 1'b0;
            bus.ack   <= 4'd0;
            bus.rdata <= 16'h0000;
        end else begin
            bus.ack <= 4'd0;
            if (state == S_IDLE && gnt_found) begin
                sel_q <= gnt_idx;
                g_wr  <= bus.wr[gnt_idx];
            end
            if (done_ok || to_hit) begin
                bus.ack   <= 4'b0001 << sel_q;
                bus.rdata <= done_ok ? bus.mem_rdata : 16'h0000;
                ptr       <= sel_q + 2'd1;
            end
        end
    end

    assign bus.mem_en    = (state == S_ISSUE);
    assign bus.mem_wr    = (state == S_ISSUE) && g_wr;
    assign bus.busy      = (state != S_IDLE);
    assign bus.sel       = sel_q;
    assign bus.state_dbg = state;

    mux4_1_16 u_addr_mux (
        .d0 (bus.addr0),
        .d1 (bus.addr1),
        .d2 (bus.addr2),
        .d3 (bus.addr3),
        .s  (sel_q),
        .y  (bus.mem_addr)
    );

    mux4_1_16 u_wdata_mux (
        .d0 (bus.wdata0),
        .d1 (bus.wdata1),
        .d2 (bus.wdata2),
        .d3 (bus.wdata3),
        .s  (sel_q),
        .y  (bus.mem_wdata)
    );
endmodule

// File: tb/tb_mem_port_arb4.sv
// Directed bench for mem_port_arb4: reset, read, write, round-robin order, spurious done,
// mid-transaction reset, and (with ARB_TIMEOUT_EN) watchdog completion.
module tb_mem_port_arb4;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mem_port_arb4_if bus ();

    mem_port_arb4 #(.TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [1:0] rr_exp [5];

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.req       = 4'd0;
        bus.wr        = 4'd0;
        bus.addr0     = 16'h0A00;
        bus.addr1     = 16'h0000;
        bus.addr2     = 16'h0C00;
        bus.addr3     = 16'h0000;
        bus.wdata0    = 16'h0000;
        bus.wdata1    = 16'h0000;
        bus.wdata2    = 16'h0000;
        bus.wdata3    = 16'h0000;
        bus.mem_done  = 1'b0;
        bus.mem_rdata = 16'h0000;

        // reset state
        tick();
        tick();
        chk("rst_sel",    16'(bus.sel),    16'd0);
        chk("rst_ack",    16'(bus.ack),    16'd0);
        chk("rst_rdata",  bus.rdata,       16'h0000);
        chk("rst_mem_en", 16'(bus.mem_en), 16'd0);
        chk("rst_busy",   16'(bus.busy),   16'd0);
        chk("rst_state",  16'(bus.state_dbg), 16'd0);
        rst_n = 1'b1;

        // single read from requester 1
        bus.req   = 4'b0010;
        bus.addr1 = 16'h1234;
        tick();
        chk("rd_mem_en",  16'(bus.mem_en), 16'd1);
        chk("rd_mem_wr",  16'(bus.mem_wr), 16'd0);
        chk("rd_sel",     16'(bus.sel),    16'd1);
        chk("rd_addr",    bus.mem_addr,    16'h1234);
        chk("rd_busy",    16'(bus.busy),   16'd1);
        tick();
        chk("rd_wait_en",  16'(bus.mem_en), 16'd0);
        chk("rd_wait_ack", 16'(bus.ack),    16'd0);
        bus.mem_done  = 1'b1;
        bus.mem_rdata = 16'hBEEF;
        tick();
        chk("rd_ack",   16'(bus.ack),  16'b0010);
        chk("rd_rdata", bus.rdata,     16'hBEEF);
        chk("rd_idle",  16'(bus.busy), 16'd0);
        bus.mem_done = 1'b0;
        bus.req      = 4'b0000;
        tick();
        chk("rd_ack_pulse", 16'(bus.ack), 16'd0);
        chk("rd_hold",      bus.rdata,    16'hBEEF);

        // write from requester 3
        bus.req    = 4'b1000;
        bus.wr     = 4'b1000;
        bus.addr3  = 16'h00F0;
        bus.wdata3 = 16'hA5A5;
        tick();
        chk("wr_mem_en", 16'(bus.mem_en), 16'd1);
        chk("wr_mem_wr", 16'(bus.mem_wr), 16'd1);
        chk("wr_addr",   bus.mem_addr,    16'h00F0);
        chk("wr_wdata",  bus.mem_wdata,   16'hA5A5);
        tick();
        bus.mem_done  = 1'b1;
        bus.mem_rdata = 16'h1111;
        tick();
        chk("wr_ack",   16'(bus.ack), 16'b1000);
        chk("wr_rdata", bus.rdata,    16'h1111);
        bus.mem_done = 1'b0;
        bus.req      = 4'b0000;
        bus.wr       = 4'b0000;
        tick();

        // round robin, all four requesting, ptr starts at 0
        rr_exp[0] = 2'd0;
        rr_exp[1] = 2'd1;
        rr_exp[2] = 2'd2;
        rr_exp[3] = 2'd3;
        rr_exp[4] = 2'd0;
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("rr_sel_%0d", k),    16'(bus.sel),    16'(rr_exp[k]));
            chk($sformatf("rr_mem_en_%0d", k), 16'(bus.mem_en), 16'd1);
            tick();
            bus.mem_done  = 1'b1;
            bus.mem_rdata = 16'h5000 + 16'(k);
            tick();
            bus.mem_done = 1'b0;
            chk($sformatf("rr_ack_%0d", k),   16'(bus.ack), 16'(4'b0001 << rr_exp[k]));
            chk($sformatf("rr_rdata_%0d", k), bus.rdata,    16'h5000 + 16'(k));
            if (k == 4) bus.req = 4'b0000;
        end
        tick();

        // spurious done in IDLE and ISSUE
        bus.mem_done  = 1'b1;
        bus.mem_rdata = 16'h2222;
        tick();
        chk("sp_idle_ack",  16'(bus.ack),  16'd0);
        chk("sp_idle_busy", 16'(bus.busy), 16'd0);
        chk("sp_idle_rd",   bus.rdata,     16'h5004);
        bus.req = 4'b0001;
        tick();
        chk("sp_issue_en", 16'(bus.mem_en), 16'd1);
        tick();
        chk("sp_issue_ack", 16'(bus.ack),   16'd0);
        chk("sp_wait_busy", 16'(bus.busy),  16'd1);
        bus.mem_done = 1'b0;
        tick();
        chk("sp_wait2_ack",  16'(bus.ack),  16'd0);
        chk("sp_wait2_busy", 16'(bus.busy), 16'd1);
        bus.mem_done  = 1'b1;
        bus.mem_rdata = 16'h3333;
        tick();
        chk("sp_ack",   16'(bus.ack), 16'b0001);
        chk("sp_rdata", bus.rdata,    16'h3333);
        bus.mem_done = 1'b0;
        bus.req      = 4'b0000;
        tick();

        // reset in the middle of WAIT with sel=2
        bus.req = 4'b0100;
        tick();
        chk("mr_sel", 16'(bus.sel), 16'd2);
        tick();
        chk("mr_wait", 16'(bus.state_dbg), 16'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_sel0",   16'(bus.sel),    16'd0);
        chk("mr_busy",   16'(bus.busy),   16'd0);
        chk("mr_mem_en", 16'(bus.mem_en), 16'd0);
        chk("mr_rdata",  bus.rdata,       16'h0000);
        chk("mr_state",  16'(bus.state_dbg), 16'd0);
        bus.mem_done = 1'b1;
        tick();
        chk("mr_no_ack", 16'(bus.ack), 16'd0);
        bus.mem_done = 1'b0;
        rst_n        = 1'b1;
        tick();
        chk("mr_re_sel", 16'(bus.sel),    16'd2);
        chk("mr_re_en",  16'(bus.mem_en), 16'd1);
        chk("mr_re_addr", bus.mem_addr,   16'h0C00);
        tick();
        bus.mem_done  = 1'b1;
        bus.mem_rdata = 16'h4444;
        tick();
        chk("mr_ack",   16'(bus.ack), 16'b0100);
        chk("mr_rdata", bus.rdata,    16'h4444);
        bus.mem_done = 1'b0;
        bus.req      = 4'b0000;
        tick();

`ifdef ARB_TIMEOUT_EN
        // watchdog: requester 0, memory never answers
        bus.req = 4'b0001;
        tick();
        chk("to_en", 16'(bus.mem_en), 16'd1);
        tick();
        for (int j = 0; j < 15; j++) begin
            tick();
            chk($sformatf("to_wait_ack_%0d", j), 16'(bus.ack), 16'd0);
        end
        tick();
        chk("to_ack",   16'(bus.ack), 16'b0001);
        chk("to_err",   16'(bus.err), 16'd1);
        chk("to_rdata", bus.rdata,    16'h0000);
        bus.req = 4'b0010;
        tick();
        chk("to_err_clr", 16'(bus.err), 16'd0);
        chk("to_next_sel", 16'(bus.sel), 16'd1);
        tick();
        bus.mem_done  = 1'b1;
        bus.mem_rdata = 16'h6666;
        tick();
        chk("to_next_ack", 16'(bus.ack), 16'b0010);
        chk("to_next_err", 16'(bus.err), 16'd0);
        chk("to_next_rd",  bus.rdata,    16'h6666);
        bus.mem_done = 1'b0;
        bus.req      = 4'b0000;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arb4.md
Name: mem_port_arb4

Overview:
- Four-requester round-robin arbiter for the single shared 16-bit memory port.
- Selects one requester and drives the 2-bit select of the 16-bit 4:1 address and write-data muxes (mux4_1_16, instantiated internally).
- Sequences a one-cycle issue, waits for memory completion, then returns an ack pulse and the read data.
- Sits between the fetch/load-store/debug/DMA clients and the memory model.

Parameters:
- TIMEOUT, 15: WAIT cycles without mem_done before forced completion. Used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  4  per-requester request; bit i = requester i.
- wr  in  4  per-requester write flag, sampled with req.
- addr0..addr3  in  16 each  requester addresses.
- wdata0..wdata3  in  16 each  requester write data.
- mem_done  in  1  memory completion strobe.
- mem_rdata  in  16  memory read data, valid with mem_done.
- mem_en  out  1  one-cycle access strobe to memory.
- mem_wr  out  1  write qualifier for mem_en.
- mem_addr  out  16  muxed address.
- mem_wdata  out  16  muxed write data.
- sel  out  2  index of the granted requester; drives the muxes.
- ack  out  4  one-hot completion pulse to the granted requester.
- rdata  out  16  read data returned with ack.
- busy  out  1  high in ISSUE and WAIT.
- err  out  1  timeout flag with ack; exists only with ARB_TIMEOUT_EN.

Behaviour:
- Reset (rst_n low, asynchronous) forces: state IDLE, ptr=0, sel=0, ack=0, rdata=0, mem_en=0, mem_wr=0, busy=0, err=0.
- Reset mid-transaction aborts it with no ack. Requesters must re-request.
- State IDLE:
  - If req is nonzero, grant the first set bit searching ptr, ptr+1, … mod 4.
  - Register sel to the granted index and latch g_wr=wr[sel]. Go to ISSUE.
  - If req is zero, stay in IDLE.
- State ISSUE (exactly 1 cycle): mem_en=1, mem_wr=g_wr, busy=1. Go to WAIT. Clear the WAIT counter.
- State WAIT:
  - busy=1. On mem_done: next edge pulses ack[sel]=1 for one cycle and sets rdata=mem_rdata (writes also capture mem_rdata).
  - On that same edge, ptr=sel+1 (mod 4) and state returns to IDLE.
- mem_addr and mem_wdata are combinational: mux4_1_16 outputs selected by sel in every state. They are valid for memory in ISSUE and WAIT.
- mem_done outside WAIT is ignored; memory never completes in the ISSUE cycle.
- Latency: req seen in IDLE at edge 0 → mem_en high in cycle 1 → mem_done earliest in cycle 2 → ack high in cycle 3.
- Minimum back-to-back spacing is 3 cycles per grant. ack returns to IDLE, and the next grant is evaluated in that same IDLE cycle.
- Requesters hold req, wr, addr and wdata stable until their ack.
- Dropping req before ack is a protocol violation; the arbiter still completes the transaction.
- A requester that keeps req high after ack is re-arbitrated. Round-robin guarantees every other pending requester is served first.
- Fairness bound: a continuously pending requester is granted within 4 grants.
- rdata holds its value until the next ack.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A 4-bit WAIT counter increments each WAIT cycle without mem_done.
  - When it reaches TIMEOUT, the next edge pulses ack[sel] with err=1, sets rdata=16'h0000, advances ptr and returns to IDLE.
  - mem_done in the same cycle as the counter reaching TIMEOUT takes priority: normal ack with err=0.
  - err is otherwise 0.
- Undefined: no counter, no err port; WAIT persists until mem_done.

Test Plan:
- Reset: rst_n low mid-WAIT with sel=2 → outputs all zero immediately, no ack. After release, req=4'b0100 → sel=2, mem_en in the next cycle.
- Single read: req=4'b0010, wr=0, addr1=16'h1234, mem_done one cycle after mem_en with mem_rdata=16'hBEEF → mem_addr=16'h1234, ack=4'b0010 and rdata=16'hBEEF exactly 3 cycles after req.
- Write: req=4'b1000, wr=4'b1000, addr3=16'h00F0, wdata3=16'hA5A5 → mem_en=1, mem_wr=1, mem_addr=16'h00F0, mem_wdata=16'hA5A5, then ack=4'b1000.
- Round-robin: req=4'b1111 held high, immediate mem_done each time → grant order sel=0,1,2,3,0. ptr wraps 3→0.
- Spurious done: mem_done pulsed in IDLE and in ISSUE → no ack. Transaction completes only on the WAIT-cycle mem_done.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT=15): req=4'b0001, mem_done never asserted → ack=4'b0001 with err=1, rdata=16'h0000 after 15 WAIT cycles. Then a req=4'b0010 request is granted normally.
